// File: rtl/cpx_dot_prod_stream.sv
// cpx_dot_prod_stream
// Streaming complex dot product. Accepts paired complex samples (x, y) and
// accumulates x*y, or x*conj(y) when conj_y is set for that sample, over a
// frame of max(frame_len,1) samples. One scaled complex result per frame is
// presented on a valid/ready output with tlast pulsing alongside tvalid.
//
// Pipeline: S1 partial products, S2 complex product, S3 accumulate / output.
// A pending, un-accepted result freezes the whole block (single global enable).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_len                samples per frame, latched on the first sample
//   conj_y                   per-sample conjugate select
//   m_axis_x_tvalid, xi, xq  x sample stream
//   m_axis_y_tvalid, yi, yq  y sample stream
//   xy_tready                pair accepted when both valids and this are high
//   m_axis_product_tready    downstream ready
//   s_axis_product_tvalid/tlast, i, q   result
//
// Build option: define DOT_PROD_SAT_EN to saturate the narrowed result
// instead of wrapping it.
module cpx_dot_prod_stream #(
    parameter int X_BITS    = 12,
    parameter int Y_BITS    = 12,
    parameter int LEN_BITS  = 8,
    parameter int ACC_BITS  = 33,
    parameter int OUT_BITS  = 24,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_BITS-1:0]        frame_len,
    input  logic                       conj_y,
    input  logic                       m_axis_x_tvalid,
    input  logic signed [X_BITS-1:0]   xi,
    input  logic signed [X_BITS-1:0]   xq,
    input  logic                       m_axis_y_tvalid,
    input  logic signed [Y_BITS-1:0]   yi,
    input  logic signed [Y_BITS-1:0]   yq,
    output logic                       xy_tready,
    input  logic                       m_axis_product_tready,
    output logic                       s_axis_product_tvalid,
    output logic                       s_axis_product_tlast,
    output logic signed [OUT_BITS-1:0] i,
    output logic signed [OUT_BITS-1:0] q
);

    localparam int PW = X_BITS + Y_BITS;

`ifdef DOT_PROD_SAT_EN
    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
`endif

    function automatic logic signed [ACC_BITS-1:0] sext(input logic signed [PW-1:0] v);
        return {{(ACC_BITS-PW){v[PW-1]}}, v};
    endfunction

    // Shift (floor) then either clamp or keep the low OUT_BITS.
    function automatic logic signed [OUT_BITS-1:0] narrow(input logic signed [ACC_BITS-1:0] v);
        logic signed [ACC_BITS-1:0] s;
        s = v >>> OUT_SHIFT;
`ifdef DOT_PROD_SAT_EN
        if (s > SAT_MAX)      return SAT_MAX[OUT_BITS-1:0];
        else if (s < SAT_MIN) return SAT_MIN[OUT_BITS-1:0];
        else                  return s[OUT_BITS-1:0];
`else
        return s[OUT_BITS-1:0];
`endif
    endfunction

    // Control
    logic                en;
    logic                accept;
    logic [LEN_BITS-1:0] cnt;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] eff_len;
    logic                is_last;

    // vld_pipe[0]: S1 valid, vld_pipe[1]: S2 valid
    logic [1:0]          vld_pipe;
    logic [1:0]          last_pipe;

    logic signed [PW-1:0]       s1_ii, s1_qq, s1_qi, s1_iq;
    logic                       s1_conj;
    logic signed [ACC_BITS-1:0] s2_pi, s2_pq;
    logic signed [ACC_BITS-1:0] acc_i, acc_q;
    logic signed [ACC_BITS-1:0] sum_i, sum_q;

    assign en        = !(s_axis_product_tvalid && !m_axis_product_tready);
    assign xy_tready = en;
    assign accept    = m_axis_x_tvalid && m_axis_y_tvalid && en;

    // Length is taken live on the first sample of a frame, from len_q after.
    assign eff_len = (cnt == '0) ? ((frame_len == '0) ? LEN_BITS'(1) : frame_len) : len_q;
    assign is_last = (cnt == eff_len - LEN_BITS'(1));

    assign sum_i = acc_i + s2_pi;
    assign sum_q = acc_q + s2_pq;

    assign s_axis_product_tlast = s_axis_product_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt                   <= '0;
            len_q                 <= '0;
            vld_pipe              <= '0;
            last_pipe             <= '0;
            s1_ii                 <= '0;
            s1_qq                 <= '0;
            s1_qi                 <= '0;
            s1_iq                 <= '0;
            s1_conj               <= 1'b0;
            s2_pi                 <= '0;
            s2_pq                 <= '0;
            acc_i                 <= '0;
            acc_q                 <= '0;
            s_axis_product_tvalid <= 1'b0;
            i                     <= '0;
            q                     <= '0;
        end else if (en) begin
            // Frame counter
            if (accept) begin
                if (cnt == '0) len_q <= eff_len;
                cnt <= is_last ? '0 : cnt + LEN_BITS'(1);
            end

            // S1: partial products
            vld_pipe[0]  <= accept;
            last_pipe[0] <= accept && is_last;
            if (accept) begin
                s1_ii   <= xi * yi;
                s1_qq   <= xq * yq;
                s1_qi   <= xq * yi;
                s1_iq   <= xi * yq;
                s1_conj <= conj_y;
            end

            // S2: complex product
            vld_pipe[1]  <= vld_pipe[0];
            last_pipe[1] <= last_pipe[0];
            if (vld_pipe[0]) begin
                s2_pi <= s1_conj ? sext(s1_ii) + sext(s1_qq) : sext(s1_ii) - sext(s1_qq);
                s2_pq <= s1_conj ? sext(s1_qi) - sext(s1_iq) : sext(s1_qi) + sext(s1_iq);
            end

            // S3: accumulate; a last element dumps into the output register.
            // With en high, a held result is being taken this edge, so tvalid
            // simply follows whether a new result lands.
            s_axis_product_tvalid <= vld_pipe[1] && last_pipe[1];
            if (vld_pipe[1]) begin
                if (last_pipe[1]) begin
                    i     <= narrow(sum_i);
                    q     <= narrow(sum_q);
                    acc_i <= '0;
                    acc_q <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpx_dot_prod_stream.sv
module tb_cpx_dot_prod_stream;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        frame_len;
    logic              conj_y;
    logic              xv, yv;
    logic signed [11:0] xi, xq, yi, yq;
    logic              rdy;
    logic              xy_tready, xy_tready_s;
    logic              tvalid, tlast, tvalid_s, tlast_s;
    logic signed [7:0]  oi, oq;
    logic signed [23:0] si, sq;

    always #5 clk = ~clk;

    // Narrow 8-bit output, no shift: exercises wrap / saturation.
    cpx_dot_prod_stream #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .ACC_BITS(33),
                          .OUT_BITS(8), .OUT_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .frame_len(frame_len), .conj_y(conj_y),
        .m_axis_x_tvalid(xv), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(yv), .yi(yi), .yq(yq),
        .xy_tready(xy_tready), .m_axis_product_tready(rdy),
        .s_axis_product_tvalid(tvalid), .s_axis_product_tlast(tlast),
        .i(oi), .q(oq));

    // Wide output with a 1-bit shift: exercises floor rounding.
    cpx_dot_prod_stream #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .ACC_BITS(33),
                          .OUT_BITS(24), .OUT_SHIFT(1)) dut_s (
        .clk(clk), .rst(rst), .frame_len(frame_len), .conj_y(conj_y),
        .m_axis_x_tvalid(xv), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(yv), .yi(yi), .yq(yq),
        .xy_tready(xy_tready_s), .m_axis_product_tready(rdy),
        .s_axis_product_tvalid(tvalid_s), .s_axis_product_tlast(tlast_s),
        .i(si), .q(sq));

    int n_pass = 0;
    int n_chk  = 0;
    int n_res  = 0;

    typedef struct { int si; int sq; } res_t;
    res_t sb[$];

    // Reference frame state
    int m_cnt = 0, m_len = 1, m_acc_i = 0, m_acc_q = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int narrow8(input int v);
        int w;
`ifdef DOT_PROD_SAT_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        w = v & 255;
        if (w > 127) w -= 256;
        return w;
`endif
    endfunction

    function automatic void model_accept(input int a_i, input int a_q, input int b_i,
                                         input int b_q, input bit cj, input int fl);
        res_t r;
        if (m_cnt == 0) m_len = (fl == 0) ? 1 : fl;
        if (cj) begin
            m_acc_i += a_i * b_i + a_q * b_q;
            m_acc_q += a_q * b_i - a_i * b_q;
        end else begin
            m_acc_i += a_i * b_i - a_q * b_q;
            m_acc_q += a_q * b_i + a_i * b_q;
        end
        if (m_cnt == m_len - 1) begin
            r.si = m_acc_i; r.sq = m_acc_q;
            sb.push_back(r);
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    // Present a pair from a negedge and hold it until accepted at a posedge.
    task automatic send(input int a_i, input int a_q, input int b_i, input int b_q, input bit cj);
        int waited = 0;
        @(negedge clk);
        xv = 1'b1; yv = 1'b1; conj_y = cj;
        xi = 12'(a_i); xq = 12'(a_q); yi = 12'(b_i); yq = 12'(b_q);
        while (!xy_tready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!xy_tready) chk("accept_wait", 32'(xy_tready), 1);
        else model_accept(a_i, a_q, b_i, b_q, cj, int'(frame_len));
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        xv = 1'b0; yv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: compare at the negedge before each output handshake edge.
    always @(negedge clk) begin
        if (!rst && tvalid && rdy) begin
            res_t r;
            n_res++;
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("out_i", 32'(oi), narrow8(r.si));
                chk("out_q", 32'(oq), narrow8(r.sq));
                chk("shift_i", 32'(si), r.si >>> 1);
                chk("shift_q", 32'(sq), r.sq >>> 1);
                chk("tlast", 32'(tlast), 1);
                chk("tvalid_s", 32'(tvalid_s), 1);
            end
        end
    end

    initial begin
        logic signed [7:0] hi, hq;
        int ok;
        rst = 1'b1; frame_len = 8'd3; conj_y = 1'b0; xv = 1'b0; yv = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_i", 32'(oi), 0);
        chk("rst_q", 32'(oq), 0);
        chk("rst_ready", 32'(xy_tready), 1);

        // Frame of 3, (1+j)*2 each -> 6+6j, check latency precisely.
        frame_len = 8'd3;
        send(1, 1, 2, 0, 0);
        send(1, 1, 2, 0, 0);
        send(1, 1, 2, 0, 0);          // returns just after accept edge k
        @(negedge clk); xv = 1'b0; yv = 1'b0;
        chk("lat_k", 32'(tvalid), 0);
        @(negedge clk); chk("lat_k1", 32'(tvalid), 0);
        @(negedge clk); chk("lat_k2", 32'(tvalid), 1);
        chk("val_i", 32'(oi), 6);
        chk("val_q", 32'(oq), 6);
        @(negedge clk); chk("lat_k3", 32'(tvalid), 0);

        // j*j with and without conjugate
        frame_len = 8'd2;
        send(0, 1, 0, 1, 0); send(0, 1, 0, 1, 0);
        send(0, 1, 0, 1, 1); send(0, 1, 0, 1, 1);
        idle(4);

        // Odd negative values through the shifted instance (floor check)
        frame_len = 8'd1;
        send(-3, -3, 1, 0, 0);
        idle(4);

        // Backpressure: hold a result for 5 cycles with valids kept high
        frame_len = 8'd2;
        @(posedge clk); #1 rdy = 1'b0;
        fork
            begin
                send(1, 0, 3, 0, 0); send(1, 0, 3, 0, 0);
                send(2, 1, 1, 1, 0); send(2, 1, 1, 1, 0);
            end
            begin
                ok = 0;
                for (int w = 0; w < 50 && !ok; w++) begin
                    @(negedge clk);
                    if (tvalid) ok = 1;
                end
                chk("stall_seen", 32'(tvalid), 1);
                hi = oi; hq = oq;
                chk("stall_val", 32'(oi), 6);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tvalid", 32'(tvalid), 1);
                    chk("stall_i", 32'(oi), 32'(hi));
                    chk("stall_q", 32'(oq), 32'(hq));
                    chk("stall_ready", 32'(xy_tready), 0);
                end
                @(posedge clk); #1 rdy = 1'b1;
            end
        join
        idle(5);

        // frame_len=0 behaves as 1: four back-to-back results
        frame_len = 8'd0;
        for (int k = 1; k <= 4; k++) send(k, 0, 1, 0, 0);
        idle(5);

        // Reset mid-frame discards the partial sum
        frame_len = 8'd4;
        send(5, 0, 1, 0, 0); send(5, 0, 1, 0, 0);
        @(negedge clk); xv = 1'b0; yv = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
        chk("rst2_tvalid", 32'(tvalid), 0);
        chk("rst2_i", 32'(oi), 0);
        chk("rst2_ready", 32'(xy_tready), 1);
        for (int k = 0; k < 4; k++) send(1, 0, 1, 0, 0);
        idle(5);

        // 300 into 8 bits: 127 saturated, 44 wrapped
        frame_len = 8'd3;
        for (int k = 0; k < 3; k++) send(100, 0, 1, 0, 0);
        idle(4);
        chk("big_i", 32'(oi),
`ifdef DOT_PROD_SAT_EN
            127
`else
            44
`endif
        );

        // Random frame with mixed conjugate flags
        frame_len = 8'd5;
        for (int k = 0; k < 5; k++)
            send($urandom_range(4095) - 2048, $urandom_range(4095) - 2048,
                 $urandom_range(4095) - 2048, $urandom_range(4095) - 2048,
                 1'($urandom_range(1)));
        idle(6);

        chk("sb_drained", sb.size(), 0);
        chk("result_count", n_res, 13);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
